mii_rx_checker: RTL and testbench
=================================

// Module: mii_rx_checker
// PURPOSE
//  Receive-side checker for the 64b/8-lane MII stream (IDLE 0x07, START 0xFB in lane 0, TERM 0xFD).
//  Sits opposite the stream generator on the MII bus. Delineates frames, checks the payload pattern,
//  measures frame length and inter-packet gap, and reports per-frame status, error pulses and
//  saturating statistics counters.
// PARAMETERS
//  DATA_WIDTH   64     data bus width; 8 lanes of 8 bits, lane 0 = [7:0]
//  CTRL_WIDTH   8      control bus width; one bit per lane
//  IDLE_CODE    8'h07  idle character
//  START_CODE   8'hFB  start character; valid only in lane 0
//  TERM_CODE    8'hFD  terminate character
//  DATA_BYTE    8'hAA  expected value of every payload byte
//  MIN_IPG      1      minimum full-IDLE words between a TERM word and the next START word
//  LEN_WIDTH    16     width of the frame-length output
//  CNT_WIDTH    16     width of the statistics counters
// PORTS
//  clk           in   1           clock
//  i_rst_n       in   1           asynchronous reset, active-low
//  i_rx_data     in   DATA_WIDTH  MII data
//  i_rx_ctrl     in   CTRL_WIDTH  MII control; 1 = control character in that lane
//  o_frame_done  out  1           1-cycle pulse: frame ended with a well-formed TERM word
//  o_frame_ok    out  1           valid with o_frame_done; 1 = no data mismatch in the frame
//  o_frame_len   out  LEN_WIDTH   valid with o_frame_done; payload bytes, START/TERM excluded
//  o_err         out  1           1-cycle error pulse
//  o_err_code    out  3           valid with o_err: 1 bad idle, 2 data mismatch, 3 bad term, 4 start in payload, 5 IPG short
//  o_frame_cnt   out  CNT_WIDTH   count of good frames; saturates
//  o_err_cnt     out  CNT_WIDTH   count of o_err pulses; saturates
// BEHAVIOUR
//  Reset state: all outputs 0; FSM in UNSYNC; length, IPG and bad-frame registers cleared.
//  Timing: every output is registered. Response appears on the clock edge after the input word is sampled, so latency is 1 cycle.
//  Word classes:
//   - IDLEW: ctrl=8'hFF and all lanes = IDLE_CODE.
//   - STARTW: ctrl=8'h01, lane0=START_CODE.
//   - DATAW: ctrl=8'h00.
//   - TERMW(p): ctrl bits [p-1:0]=0 and bits [7:p]=1, with p in 0..7; lane p=TERM_CODE; lanes above p = IDLE_CODE.
//  FSM states:
//   - UNSYNC:
//      - Ignore all input; no errors are raised.
//      - On IDLEW go to IDLE with ipg=MIN_IPG. This absorbs the all-zero word after reset.
//   - IDLE:
//      - IDLEW: ipg++ (saturates at 255).
//      - STARTW: go to PAYLOAD; len=7; check lanes 1..7 against DATA_BYTE.
//        If ipg<MIN_IPG, also err 5; the frame is still accepted.
//      - Any other word: err 1; stay in IDLE; ipg=0.
//   - PAYLOAD:
//      - DATAW: len+=8; if any lane != DATA_BYTE, set bad flag.
//      - TERMW(p): len+=p; lanes 0..p-1 are checked; o_frame_done=1; o_frame_ok=!bad;
//        o_frame_len=len (saturating); go to IDLE; ipg=0.
//      - STARTW: err 4; drop the current frame (no frame_done); restart the frame from this word with len=7.
//      - Any other word: err 3; drop the frame; go to IDLE; ipg=0.
//  Data mismatch: err 2 fires once per frame, on the first mismatching word. The frame continues.
//  Good frame: o_frame_cnt increments only when o_frame_done=1 and o_frame_ok=1.
//  Length and counters: all saturate, never wrap. len saturates at 2^LEN_WIDTH-1.
//  Simultaneous errors in one word: report the lowest code. o_err_cnt still increments by 1.
//  Reset asserted mid-frame: everything returns to reset state; the partial frame is not reported.
// TESTING
//  1. Reset, 1 zero word, 3 IDLEW, STARTW, 2 DATAW, TERMW(3) -> no o_err; frame_done, ok=1, len=26; frame_cnt=1.
//  2. Each TERMW(p) for p=0..7 after 1 DATAW -> len=7+8+p; 8 frames counted; err_cnt=0.
//  3. Byte 0x55 in lane 4 of the 2nd DATAW -> one o_err code 2; frame_done with ok=0; frame_cnt unchanged.
//  4. STARTW then STARTW then TERMW(0) -> err 4; a single frame_done with len=7.
//  5. TERMW followed immediately by STARTW, with MIN_IPG=1 -> err 5; the next frame still completes with ok=1.
//  6. Lane 2 of an IDLEW = 0x00 while in IDLE -> err 1; err_cnt=1. Reset asserted mid-PAYLOAD -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/mii_rx_checker.sv
// mii_rx_checker: receive-side checker for the 64b/8-lane MII stream.
// Delineates frames, checks payload bytes, reports status and statistics.
module mii_rx_checker #(
    parameter int         DATA_WIDTH = 64,
    parameter int         CTRL_WIDTH = 8,
    parameter logic [7:0] IDLE_CODE  = 8'h07,
    parameter logic [7:0] START_CODE = 8'hFB,
    parameter logic [7:0] TERM_CODE  = 8'hFD,
    parameter logic [7:0] DATA_BYTE  = 8'hAA,
    parameter int         MIN_IPG    = 1,
    parameter int         LEN_WIDTH  = 16,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_frame_done,
    output logic                  o_frame_ok,
    output logic [LEN_WIDTH-1:0]  o_frame_len,
    output logic                  o_err,
    output logic [2:0]            o_err_code,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    localparam int LANES = CTRL_WIDTH;
    localparam int POS_W = $clog2(LANES);

    localparam logic [1:0] ST_UNSYNC  = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam logic [7:0]            IPG_MIN    = MIN_IPG[7:0];
    localparam logic [7:0]            IPG_MAX    = 8'hFF;
    localparam logic [CTRL_WIDTH-1:0] CTRL_ONES  = '1;
    localparam logic [CTRL_WIDTH-1:0] CTRL_START = CTRL_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_SEED   = LEN_WIDTH'(LANES - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_WORD   = LEN_WIDTH'(LANES);

    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [7:0]           ipg_q, ipg_d;
    logic                 bad_q, bad_d;

    logic                 done_d;
    logic                 ok_d;
    logic [LEN_WIDTH-1:0] flen_d;
    logic [5:1]           err_vec;
    logic                 err_d;
    logic [2:0]           err_code_d;
    logic [CNT_WIDTH-1:0] frame_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_d;

    logic [7:0]       lane [LANES];
    logic [LANES-1:0] lane_idle;
    logic [LANES-1:0] lane_bad;

    logic             is_idle;
    logic             is_start;
    logic             is_data;
    logic             start_mis;
    logic             data_mis;
    logic             term_hit;
    logic [POS_W-1:0] term_pos;
    logic             term_mis;

    function automatic logic [LEN_WIDTH-1:0] len_add(
        input logic [LEN_WIDTH-1:0] a,
        input logic [LEN_WIDTH-1:0] b
    );
        logic [LEN_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LEN_WIDTH] ? '1 : s[LEN_WIDTH-1:0];
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane[i]      = i_rx_data[8*i +: 8];
        assign lane_idle[i] = lane[i] == IDLE_CODE;
        assign lane_bad[i]  = lane[i] != DATA_BYTE;
    end

    assign is_idle   = (i_rx_ctrl == CTRL_ONES) && (&lane_idle);
    assign is_start  = (i_rx_ctrl == CTRL_START) &&
                       (lane[0] == START_CODE);
    assign is_data   = i_rx_ctrl == '0;
    assign start_mis = |lane_bad[LANES-1:1];
    assign data_mis  = |lane_bad;

    // TERM in lane p: data below, control from p up, IDLE above p
    always_comb begin
        term_hit = 1'b0;
        term_pos = '0;
        term_mis = 1'b0;
        for (int p = 0; p < LANES; p++) begin
            if ((i_rx_ctrl == (CTRL_ONES << p)) &&
                (lane[p] == TERM_CODE) &&
                (&(lane_idle | (CTRL_ONES >> (LANES - 1 - p))))) begin
                term_hit = 1'b1;
                term_pos = POS_W'(p);
                term_mis = |(lane_bad & ~(CTRL_ONES << p));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ipg_d   = ipg_q;
        bad_d   = bad_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;
        flen_d  = '0;
        err_vec = '0;

        unique case (state_q)
            ST_UNSYNC: begin
                if (is_idle) begin
                    state_d = ST_IDLE;
                    ipg_d   = IPG_MIN;
                end
            end

            ST_IDLE: begin
                unique case (1'b1)
                    is_idle: begin
                        if (ipg_q != IPG_MAX)
                            ipg_d = ipg_q + 8'd1;
                    end
                    is_start: begin
                        state_d    = ST_PAYLOAD;
                        len_d      = LEN_SEED;
                        bad_d      = start_mis;
                        err_vec[2] = start_mis;
                        err_vec[5] = ipg_q < IPG_MIN;
                    end
                    default: begin
                        err_vec[1] = 1'b1;
                        ipg_d      = '0;
                    end
                endcase
            end

            ST_PAYLOAD: begin
                unique case (1'b1)
                    is_data: begin
                        len_d      = len_add(len_q, LEN_WORD);
                        bad_d      = bad_q | data_mis;
                        err_vec[2] = data_mis & ~bad_q;
                    end
                    term_hit: begin
                        done_d     = 1'b1;
                        ok_d       = ~(bad_q | term_mis);
                        flen_d     = len_add(len_q,
                                             LEN_WIDTH'(term_pos));
                        err_vec[2] = term_mis & ~bad_q;
                        state_d    = ST_IDLE;
                        ipg_d      = '0;
                        len_d      = '0;
                        bad_d      = 1'b0;
                    end
                    is_start: begin
                        // abandon the open frame, new one starts here
                        err_vec[4] = 1'b1;
                        len_d      = LEN_SEED;
                        bad_d      = start_mis;
                        err_vec[2] = start_mis;
                    end
                    default: begin
                        err_vec[3] = 1'b1;
                        state_d    = ST_IDLE;
                        ipg_d      = '0;
                        len_d      = '0;
                        bad_d      = 1'b0;
                    end
                endcase
            end

            default: begin
                state_d = ST_UNSYNC;
            end
        endcase
    end

    // several errors in one word: the lowest code wins
    always_comb begin
        err_code_d = '0;
        for (int c = 5; c >= 1; c--) begin
            if (err_vec[c])
                err_code_d = 3'(c);
        end
    end

    assign err_d = |err_vec;

    assign frame_cnt_d = (done_d && ok_d && (o_frame_cnt != '1)) ?
                         o_frame_cnt + CNT_WIDTH'(1) : o_frame_cnt;

    assign err_cnt_d = (err_d && (o_err_cnt != '1)) ?
                       o_err_cnt + CNT_WIDTH'(1) : o_err_cnt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_UNSYNC;
            len_q        <= '0;
            ipg_q        <= '0;
            bad_q        <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_frame_len  <= '0;
            o_err        <= 1'b0;
            o_err_code   <= '0;
            o_frame_cnt  <= '0;
            o_err_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            ipg_q        <= ipg_d;
            bad_q        <= bad_d;
            o_frame_done <= done_d;
            o_frame_ok   <= ok_d;
            o_frame_len  <= flen_d;
            o_err        <= err_d;
            o_err_code   <= err_code_d;
            o_frame_cnt  <= frame_cnt_d;
            o_err_cnt    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_mii_rx_checker.sv
// tb_mii_rx_checker: directed and random stimulus for mii_rx_checker,
// checked every cycle against a word-level behavioural model.
module tb_mii_rx_checker;

    localparam int K_IDLE  = 0;
    localparam int K_START = 1;
    localparam int K_DATA  = 2;
    localparam int K_TERM  = 3;
    localparam int K_OTHER = 4;
    localparam int MIN_IPG = 1;
    localparam int SAT     = 65535;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] rx_data;
    logic [7:0]  rx_ctrl;
    logic        o_frame_done;
    logic        o_frame_ok;
    logic [15:0] o_frame_len;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_err_cnt;

    always #5 clk = ~clk;

    mii_rx_checker dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_rx_data    (rx_data),
        .i_rx_ctrl    (rx_ctrl),
        .o_frame_done (o_frame_done),
        .o_frame_ok   (o_frame_ok),
        .o_frame_len  (o_frame_len),
        .o_err        (o_err),
        .o_err_code   (o_err_code),
        .o_frame_cnt  (o_frame_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state
    bit m_sync, m_in, m_mis;
    int m_len, m_gap, m_fcnt, m_ecnt;
    int m_codes[$];

    // model next outputs, and expected outputs currently on the pins
    bit n_done, n_ok, n_err;
    int n_len, n_code;
    bit e_done, e_ok, e_err;
    int e_len, e_code, e_fcnt, e_ecnt;

    // observed DUT events for directed checks
    int seen_err, seen_done, last_code, last_len;
    bit last_ok;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] w_idle();
        return {8'hFF, {8{8'h07}}};
    endfunction

    function automatic logic [71:0] w_start();
        return {8'h01, {7{8'hAA}}, 8'hFB};
    endfunction

    function automatic logic [71:0] w_data();
        return {8'h00, {8{8'hAA}}};
    endfunction

    function automatic logic [71:0] w_term(input int p);
        logic [71:0] w;
        logic [7:0]  ones;
        ones = 8'hFF;
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = (i < p) ? 8'hAA : (i == p) ? 8'hFD : 8'h07;
        w[71:64] = ones << p;
        return w;
    endfunction

    function automatic logic [71:0] w_put(input logic [71:0] w,
                                          input int l,
                                          input logic [7:0] v);
        logic [71:0] r;
        r = w;
        r[8*l +: 8] = v;
        return r;
    endfunction

    function automatic logic [7:0] bad_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA)
            b = 8'h00;
        return b;
    endfunction

    function automatic logic [71:0] w_junk();
        return {8'($urandom_range(1, 255)), $urandom, $urandom};
    endfunction

    function automatic int kind_of(input logic [71:0] w, output int p);
        logic [7:0] c;
        logic [7:0] ones;
        bit all_idle;
        c = w[71:64];
        ones = 8'hFF;
        p = 0;
        all_idle = 1'b1;
        for (int i = 0; i < 8; i++)
            if (w[8*i +: 8] != 8'h07)
                all_idle = 1'b0;
        if (c == 8'hFF && all_idle)
            return K_IDLE;
        if (c == 8'h01 && w[7:0] == 8'hFB)
            return K_START;
        if (c == 8'h00)
            return K_DATA;
        while (!c[p])
            p++;
        if (c != (ones << p))
            return K_OTHER;
        if (w[8*p +: 8] != 8'hFD)
            return K_OTHER;
        for (int i = p + 1; i < 8; i++)
            if (w[8*i +: 8] != 8'h07)
                return K_OTHER;
        return K_TERM;
    endfunction

    task automatic note_bytes(input logic [71:0] w, input int lo,
                              input int hi);
        int bad;
        bad = 0;
        for (int i = lo; i < hi; i++)
            if (w[8*i +: 8] != 8'hAA)
                bad++;
        if (bad > 0) begin
            if (!m_mis)
                m_codes.push_back(2);
            m_mis = 1'b1;
        end
    endtask

    task automatic open_frame(input logic [71:0] w);
        m_in  = 1'b1;
        m_len = 7;
        m_mis = 1'b0;
        note_bytes(w, 1, 8);
    endtask

    task automatic model(input logic [71:0] w);
        int k, p;
        m_codes.delete();
        k = kind_of(w, p);
        n_done = 1'b0;
        n_ok   = 1'b0;
        n_len  = 0;
        if (!m_sync) begin
            if (k == K_IDLE) begin
                m_sync = 1'b1;
                m_gap  = MIN_IPG;
            end
        end else if (!m_in) begin
            if (k == K_IDLE) begin
                m_gap = (m_gap < 255) ? m_gap + 1 : 255;
            end else if (k == K_START) begin
                if (m_gap < MIN_IPG)
                    m_codes.push_back(5);
                open_frame(w);
            end else begin
                m_codes.push_back(1);
                m_gap = 0;
            end
        end else begin
            case (k)
                K_DATA: begin
                    m_len += 8;
                    note_bytes(w, 0, 8);
                end
                K_TERM: begin
                    m_len += p;
                    note_bytes(w, 0, p);
                    n_done = 1'b1;
                    n_ok   = !m_mis;
                    n_len  = (m_len > SAT) ? SAT : m_len;
                    if (n_ok && m_fcnt < SAT)
                        m_fcnt++;
                    m_in  = 1'b0;
                    m_gap = 0;
                end
                K_START: begin
                    m_codes.push_back(4);
                    open_frame(w);
                end
                default: begin
                    m_codes.push_back(3);
                    m_in  = 1'b0;
                    m_gap = 0;
                end
            endcase
        end
        n_err  = m_codes.size() != 0;
        n_code = 0;
        if (n_err) begin
            n_code = 7;
            foreach (m_codes[i])
                if (m_codes[i] < n_code)
                    n_code = m_codes[i];
            if (m_ecnt < SAT)
                m_ecnt++;
        end
    endtask

    task automatic step(input logic [71:0] w);
        rx_ctrl = w[71:64];
        rx_data = w[63:0];
        model(w);
        @(posedge clk);
        #1;
        e_done = n_done;
        e_ok   = n_ok;
        e_len  = n_len;
        e_err  = n_err;
        e_code = n_code;
        e_fcnt = m_fcnt;
        e_ecnt = m_ecnt;
        if (o_err) begin
            seen_err++;
            last_code = int'(o_err_code);
        end
        if (o_frame_done) begin
            seen_done++;
            last_len = int'(o_frame_len);
            last_ok  = o_frame_ok;
        end
    endtask

    task automatic rst_assert();
        i_rst_n = 1'b0;
        rx_data = '0;
        rx_ctrl = '0;
        m_sync = 1'b0;
        m_in   = 1'b0;
        m_mis  = 1'b0;
        m_len  = 0;
        m_gap  = 0;
        m_fcnt = 0;
        m_ecnt = 0;
        e_done = 1'b0;
        e_ok   = 1'b0;
        e_err  = 1'b0;
        e_len  = 0;
        e_code = 0;
        e_fcnt = 0;
        e_ecnt = 0;
    endtask

    task automatic rst_release(input int cycles);
        repeat (cycles) @(posedge clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic clear_seen();
        seen_err  = 0;
        seen_done = 0;
        last_code = 0;
        last_len  = 0;
        last_ok   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("frame_done", int'(o_frame_done), int'(e_done));
            chk("err", int'(o_err), int'(e_err));
            chk("frame_cnt", int'(o_frame_cnt), e_fcnt);
            chk("err_cnt", int'(o_err_cnt), e_ecnt);
            if (e_done) begin
                chk("frame_ok", int'(o_frame_ok), int'(e_ok));
                chk("frame_len", int'(o_frame_len), e_len);
            end
            if (e_err)
                chk("err_code", int'(o_err_code), e_code);
        end
    end

    initial begin
        i_rst_n = 1'b1;
        rx_data = '0;
        rx_ctrl = '0;
        clear_seen();
        #1;
        rst_assert();
        chk_en = 1'b1;
        rst_release(2);

        // basic frame after sync
        clear_seen();
        step('0);
        repeat (3) step(w_idle());
        step(w_start());
        repeat (2) step(w_data());
        step(w_term(3));
        chk("t1_len", last_len, 26);
        chk("t1_ok", int'(last_ok), 1);
        chk("t1_done_n", seen_done, 1);
        chk("t1_errs", seen_err, 0);
        chk("t1_fcnt", int'(o_frame_cnt), 1);
        chk("t1_model_len", e_len, 26);

        // every terminate position
        for (int p = 0; p < 8; p++) begin
            step(w_idle());
            step(w_start());
            step(w_data());
            step(w_term(p));
            chk("t2_len", last_len, 15 + p);
        end
        chk("t2_fcnt", int'(o_frame_cnt), 9);
        chk("t2_ecnt", int'(o_err_cnt), 0);

        // payload mismatch
        clear_seen();
        step(w_idle());
        step(w_start());
        step(w_data());
        step(w_put(w_data(), 4, 8'h55));
        step(w_data());
        step(w_term(0));
        chk("t3_errs", seen_err, 1);
        chk("t3_code", last_code, 2);
        chk("t3_ok", int'(last_ok), 0);
        chk("t3_fcnt", int'(o_frame_cnt), 9);

        // start inside payload
        clear_seen();
        step(w_idle());
        step(w_start());
        step(w_start());
        step(w_term(0));
        chk("t4_errs", seen_err, 1);
        chk("t4_code", last_code, 4);
        chk("t4_done_n", seen_done, 1);
        chk("t4_len", last_len, 7);

        // short inter-packet gap
        clear_seen();
        step(w_idle());
        step(w_start());
        step(w_term(0));
        step(w_start());
        step(w_data());
        step(w_term(2));
        chk("t5_errs", seen_err, 1);
        chk("t5_code", last_code, 5);
        chk("t5_ok", int'(last_ok), 1);
        chk("t5_len", last_len, 17);
        chk("t5_fcnt", int'(o_frame_cnt), 12);

        // length saturation
        step(w_idle());
        step(w_start());
        repeat (8200) step(w_data());
        step(w_term(0));
        chk("sat_len", last_len, 65535);
        chk("sat_ok", int'(last_ok), 1);

        // bad idle, then reset in the middle of a frame
        rst_assert();
        rst_release(2);
        clear_seen();
        step('0);
        step(w_idle());
        step(w_put(w_idle(), 2, 8'h00));
        chk("t6_ecnt", int'(o_err_cnt), 1);
        chk("t6_code", last_code, 1);
        step(w_idle());
        step(w_start());
        step(w_data());
        step(w_term(0));
        step(w_idle());
        step(w_start());
        step(w_data());
        rst_assert();
        @(posedge clk);
        #1;
        chk("t6_rst_fcnt", int'(o_frame_cnt), 0);
        chk("t6_rst_ecnt", int'(o_err_cnt), 0);
        chk("t6_rst_done", int'(o_frame_done), 0);
        rst_release(1);
        step('0);
        step(w_idle());

        // random traffic
        for (int f = 0; f < 400; f++) begin
            int r, n;
            logic [71:0] w;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst_assert();
                rst_release($urandom_range(1, 3));
                step('0);
            end
            repeat ($urandom_range(0, 3)) step(w_idle());
            if (r >= 2 && r < 8)
                step(w_junk());
            w = w_start();
            if ($urandom_range(0, 9) == 0)
                w = w_put(w, $urandom_range(1, 7), bad_byte());
            step(w);
            n = $urandom_range(0, 6);
            for (int d = 0; d < n; d++) begin
                int r2;
                r2 = $urandom_range(0, 99);
                w = w_data();
                if (r2 < 5)
                    w = w_put(w, $urandom_range(0, 7), bad_byte());
                else if (r2 < 8)
                    w = w_start();
                else if (r2 < 11)
                    w = w_junk();
                step(w);
            end
            begin
                int p;
                p = $urandom_range(0, 7);
                w = w_term(p);
                if (p > 0 && $urandom_range(0, 9) == 0)
                    w = w_put(w, $urandom_range(0, p - 1), bad_byte());
                step(w);
            end
        end

        repeat (2) step(w_idle());
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
